// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - fetch-side and register-read-side handshake bundle of decode_stage_pipe
interface decode_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic                in_valid;
    logic                in_ready;
    logic [PC_W-1:0]     in_pc;
    logic [31:0]         in_insn;

    logic                out_valid;
    logic                out_ready;
    logic [PC_W-1:0]     out_pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [6:0]          funct7;
    logic [XLEN-1:0]     imm;
    logic [SHAMT_W-1:0]  shamt;
    logic [5:0]          fmt;
    logic                illegal;
    logic                is_muldiv;

    modport master (
        output in_valid, in_pc, in_insn, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2,
               funct7, imm, shamt, fmt, illegal, is_muldiv
    );

    modport slave (
        input  in_valid, in_pc, in_insn, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2,
               funct7, imm, shamt, fmt, illegal, is_muldiv
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - registered RV32I/RV64I decode stage with 1-entry skid buffer
// Optional M-extension decode enabled by defining DEC_MEXT_EN.
module decode_stage_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    decode_stage_pipe_if.slave bus
);
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    localparam logic [5:0] FMT_R = 6'b100000;
    localparam logic [5:0] FMT_I = 6'b010000;
    localparam logic [5:0] FMT_S = 6'b001000;
    localparam logic [5:0] FMT_B = 6'b000100;
    localparam logic [5:0] FMT_U = 6'b000010;
    localparam logic [5:0] FMT_J = 6'b000001;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [2:0]         funct3;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [6:0]         funct7;
        logic [XLEN-1:0]    imm;
        logic [SHAMT_W-1:0] shamt;
        logic [5:0]         fmt;
        logic               illegal;
        logic               is_muldiv;
    } dec_t;

    logic [31:0] insn;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        shift_imm;
    dec_t        dec;

    dec_t out_q, out_d;
    dec_t skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic accept;

    assign insn = bus.in_insn;
    assign f3   = insn[14:12];
    assign f7   = insn[31:25];

    always_comb begin
        dec        = '0;
        imm32      = '0;
        shift_imm  = 1'b0;
        dec.pc     = bus.in_pc;
        dec.opcode = insn[6:0];
        if (insn[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (insn[6:0])
                7'h37, 7'h17: begin
                    dec.rd  = insn[11:7];
                    imm32   = {insn[31:12], 12'h000};
                    dec.fmt = FMT_U;
                end
                7'h6F: begin
                    dec.rd  = insn[11:7];
                    imm32   = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
                    dec.fmt = FMT_J;
                end
                7'h67, 7'h03: begin
                    dec.rd     = insn[11:7];
                    dec.funct3 = f3;
                    dec.rs1    = insn[19:15];
                    imm32      = {{20{insn[31]}}, insn[31:20]};
                    dec.fmt    = FMT_I;
                end
                7'h13: begin
                    dec.rd     = insn[11:7];
                    dec.funct3 = f3;
                    dec.rs1    = insn[19:15];
                    dec.fmt    = FMT_I;
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        // Shift-immediates report shamt zero-extended, not the sign-extended I field
                        shift_imm  = 1'b1;
                        dec.funct7 = f7;
                        dec.shamt  = insn[20 +: SHAMT_W];
                        if ((f7[6:1] != 6'h00 && f7[6:1] != 6'h10) || (XLEN == 32 && insn[25]))
                            dec.illegal = 1'b1;
                    end else begin
                        imm32 = {{20{insn[31]}}, insn[31:20]};
                    end
                end
                7'h23: begin
                    dec.funct3 = f3;
                    dec.rs1    = insn[19:15];
                    dec.rs2    = insn[24:20];
                    imm32      = {{20{insn[31]}}, insn[31:25], insn[11:7]};
                    dec.fmt    = FMT_S;
                end
                7'h63: begin
                    dec.funct3 = f3;
                    dec.rs1    = insn[19:15];
                    dec.rs2    = insn[24:20];
                    imm32      = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
                    dec.fmt    = FMT_B;
                end
                7'h33: begin
                    dec.rd     = insn[11:7];
                    dec.funct3 = f3;
                    dec.rs1    = insn[19:15];
                    dec.rs2    = insn[24:20];
                    dec.funct7 = f7;
                    dec.fmt    = FMT_R;
                    case (f7)
                        7'h00: dec.is_muldiv = 1'b0;
                        7'h20: if (f3 != 3'b000 && f3 != 3'b101) dec.illegal = 1'b1;
`ifdef DEC_MEXT_EN
                        7'h01: dec.is_muldiv = 1'b1;
`else
                        7'h01: dec.illegal = 1'b1;
`endif
                        default: dec.illegal = 1'b1;
                    endcase
                end
                7'h73: begin
                    if (insn != 32'h0000_0073 && insn != 32'h0010_0073)
                        dec.illegal = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        dec.imm = shift_imm ? XLEN'(dec.shamt) : XLEN'($signed(imm32));
        // Trap logic still needs pc and opcode of an illegal word; everything else is cleared
        if (dec.illegal) begin
            dec.rd        = '0;
            dec.funct3    = '0;
            dec.rs1       = '0;
            dec.rs2       = '0;
            dec.funct7    = '0;
            dec.imm       = '0;
            dec.shamt     = '0;
            dec.fmt       = '0;
            dec.is_muldiv = 1'b0;
        end
    end

    assign accept = bus.in_valid && in_ready_q && !flush;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.opcode    = out_q.opcode;
    assign bus.rd        = out_q.rd;
    assign bus.funct3    = out_q.funct3;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.funct7    = out_q.funct7;
    assign bus.imm       = out_q.imm;
    assign bus.shamt     = out_q.shamt;
    assign bus.fmt       = out_q.fmt;
    assign bus.illegal   = out_q.illegal;
    assign bus.is_muldiv = out_q.is_muldiv;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe (XLEN=32)
module tb_decode_stage_pipe;
    logic clock = 1'b0;
    logic reset;
    logic flush;

    always #5 clock = ~clock;

    decode_stage_pipe_if #(.XLEN(32), .PC_W(32)) bus ();

    decode_stage_pipe #(.XLEN(32), .PC_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [5:0]  fmt;
        logic        ill;
        logic        md;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc_cnt = 32'h0000_1000;

    logic [31:0] tbl [14] = '{32'h00500093, 32'h12345137, 32'hFE000EE3, 32'h4041D193,
                              32'hFFFFFFFF, 32'h023100B3, 32'h403100B3, 32'h403110B3,
                              32'h00000073, 32'h00100073, 32'h02009093, 32'h008000EF,
                              32'h0020A623, 32'h00000001};
    logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h73};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       u_rd, u_f3, u_rs1, u_rs2, u_f7, bad;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        {u_rd, u_f3, u_rs1, u_rs2, u_f7, bad} = '0;
        if (w[1:0] != 2'b11) begin
            bad = 1'b1;
        end else if (op == 7'h37 || op == 7'h17) begin
            u_rd = 1'b1; e.imm = {w[31:12], 12'h000}; e.fmt = 6'b000010;
        end else if (op == 7'h6F) begin
            u_rd = 1'b1; e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; e.fmt = 6'b000001;
        end else if (op == 7'h67 || op == 7'h03 || (op == 7'h13 && f3 != 3'b001 && f3 != 3'b101)) begin
            u_rd = 1'b1; u_f3 = 1'b1; u_rs1 = 1'b1;
            e.imm = {{20{w[31]}}, w[31:20]}; e.fmt = 6'b010000;
        end else if (op == 7'h13) begin
            u_rd = 1'b1; u_f3 = 1'b1; u_rs1 = 1'b1; u_f7 = 1'b1;
            e.sh = w[24:20]; e.imm = {27'd0, w[24:20]}; e.fmt = 6'b010000;
            bad = !(f7[6:1] == 6'd0 || f7[6:1] == 6'h10) || w[25];
        end else if (op == 7'h23) begin
            u_f3 = 1'b1; u_rs1 = 1'b1; u_rs2 = 1'b1;
            e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.fmt = 6'b001000;
        end else if (op == 7'h63) begin
            u_f3 = 1'b1; u_rs1 = 1'b1; u_rs2 = 1'b1;
            e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; e.fmt = 6'b000100;
        end else if (op == 7'h33) begin
            u_rd = 1'b1; u_f3 = 1'b1; u_rs1 = 1'b1; u_rs2 = 1'b1; u_f7 = 1'b1;
            e.fmt = 6'b100000;
            if (f7 == 7'h20) bad = !(f3 == 3'b000 || f3 == 3'b101);
            else if (f7 == 7'h01) begin
`ifdef DEC_MEXT_EN
                e.md = 1'b1;
`else
                bad = 1'b1;
`endif
            end else if (f7 != 7'h00) bad = 1'b1;
        end else if (op == 7'h73) begin
            bad = !(w == 32'h00000073 || w == 32'h00100073);
        end else begin
            bad = 1'b1;
        end
        if (u_rd)  e.rd  = w[11:7];
        if (u_f3)  e.f3  = f3;
        if (u_rs1) e.rs1 = w[19:15];
        if (u_rs2) e.rs2 = w[24:20];
        if (u_f7)  e.f7  = f7;
        if (bad) begin
            e = '0;
            e.ill = 1'b1;
        end
        e.pc = pc;
        e.op = op;
        return e;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w = tbl[$urandom_range(0, 13)];
            1: ;
            default: w[6:0] = ops[$urandom_range(0, 9)];
        endcase
        return w;
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("pc",      bus.out_pc,    e.pc);
                    check_eq("opcode",  bus.opcode,    e.op);
                    check_eq("rd",      bus.rd,        e.rd);
                    check_eq("funct3",  bus.funct3,    e.f3);
                    check_eq("rs1",     bus.rs1,       e.rs1);
                    check_eq("rs2",     bus.rs2,       e.rs2);
                    check_eq("funct7",  bus.funct7,    e.f7);
                    check_eq("imm",     bus.imm,       e.imm);
                    check_eq("shamt",   bus.shamt,     e.sh);
                    check_eq("fmt",     bus.fmt,       e.fmt);
                    check_eq("illegal", bus.illegal,   e.ill);
                    check_eq("muldiv",  bus.is_muldiv, e.md);
                end
            end
            if (flush) sb.delete();
            else if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_pc, bus.in_insn));
        end
    end

    task automatic directed(input string tag, input logic [31:0] w, input logic [31:0] e_imm,
                            input logic [4:0] e_rd, input logic [5:0] e_fmt, input logic e_ill,
                            input logic [4:0] e_sh, input logic [6:0] e_f7, input logic e_md);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_insn   = w;
        bus.in_pc     = pc_cnt;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        pc_cnt += 4;
        check_eq({tag, "_valid"},   bus.out_valid, 1);
        check_eq({tag, "_opcode"},  bus.opcode,    w[6:0]);
        check_eq({tag, "_rd"},      bus.rd,        e_rd);
        check_eq({tag, "_imm"},     bus.imm,       e_imm);
        check_eq({tag, "_fmt"},     bus.fmt,       e_fmt);
        check_eq({tag, "_illegal"}, bus.illegal,   e_ill);
        check_eq({tag, "_shamt"},   bus.shamt,     e_sh);
        check_eq({tag, "_funct7"},  bus.funct7,    e_f7);
        check_eq({tag, "_muldiv"},  bus.is_muldiv, e_md);
    endtask

    task automatic send(input logic [31:0] w);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_insn  = w;
        bus.in_pc    = pc_cnt;
        while (!bus.in_ready) begin
            if (k >= 50) begin
                check_eq("send_timeout", k, 0);
                break;
            end
            @(posedge clock); #1;
            k++;
        end
        @(posedge clock); #1;
        pc_cnt += 4;
    endtask

    initial begin
        logic [31:0] pa;
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_insn   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready",  bus.in_ready,  0);
        check_eq("rst_out_pc",    bus.out_pc,    0);
        check_eq("rst_imm",       bus.imm,       0);
        check_eq("rst_fmt",       bus.fmt,       0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("rst_in_ready_after", bus.in_ready, 1);

        directed("addi",  32'h00500093, 32'd5,        5'd1, 6'b010000, 1'b0, 5'd0, 7'h00, 1'b0);
        directed("lui",   32'h12345137, 32'h12345000, 5'd2, 6'b000010, 1'b0, 5'd0, 7'h00, 1'b0);
        directed("beq",   32'hFE000EE3, 32'hFFFFFFFC, 5'd0, 6'b000100, 1'b0, 5'd0, 7'h00, 1'b0);
        directed("srai",  32'h4041D193, 32'd4,        5'd3, 6'b010000, 1'b0, 5'd4, 7'h20, 1'b0);
        directed("ones",  32'hFFFFFFFF, 32'd0,        5'd0, 6'b000000, 1'b1, 5'd0, 7'h00, 1'b0);
`ifdef DEC_MEXT_EN
        directed("mul",   32'h023100B3, 32'd0,        5'd1, 6'b100000, 1'b0, 5'd0, 7'h01, 1'b1);
`else
        directed("mul",   32'h023100B3, 32'd0,        5'd0, 6'b000000, 1'b1, 5'd0, 7'h00, 1'b0);
`endif
        directed("sub",   32'h403100B3, 32'd0,        5'd1, 6'b100000, 1'b0, 5'd0, 7'h20, 1'b0);
        directed("badf3", 32'h403110B3, 32'd0,        5'd0, 6'b000000, 1'b1, 5'd0, 7'h00, 1'b0);
        directed("ecall", 32'h00000073, 32'd0,        5'd0, 6'b000000, 1'b0, 5'd0, 7'h00, 1'b0);
        directed("badsys",32'h00200073, 32'd0,        5'd0, 6'b000000, 1'b1, 5'd0, 7'h00, 1'b0);
        directed("sh32",  32'h02009093, 32'd0,        5'd0, 6'b000000, 1'b1, 5'd0, 7'h00, 1'b0);
        directed("jal",   32'h008000EF, 32'd8,        5'd1, 6'b000001, 1'b0, 5'd0, 7'h00, 1'b0);
        directed("sw",    32'h0020A623, 32'd12,       5'd0, 6'b001000, 1'b0, 5'd0, 7'h00, 1'b0);
        directed("rvc",   32'h00000001, 32'd0,        5'd0, 6'b000000, 1'b1, 5'd0, 7'h00, 1'b0);
        @(posedge clock); #1;

        // Backpressure: out_ready low for three edges while four instructions stream in
        bus.out_ready = 1'b0;
        pa = pc_cnt;
        send(32'h00100093);
        check_eq("bp_rdy_after1", bus.in_ready, 1);
        check_eq("bp_valid1",     bus.out_valid, 1);
        send(32'h00200113);
        check_eq("bp_rdy_after2", bus.in_ready, 0);
        bus.in_insn = 32'h00300193;
        bus.in_pc   = pc_cnt;
        @(posedge clock); #1;
        check_eq("bp_hold_pc",  bus.out_pc,   pa);
        check_eq("bp_hold_imm", bus.imm,      32'd1);
        check_eq("bp_hold_rdy", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        send(32'h00300193);
        send(32'h00400213);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check_eq("bp_sb_empty",  sb.size(),     0);
        check_eq("bp_out_valid", bus.out_valid, 0);

        // Flush with the skid full; the word offered during flush must be dropped
        bus.out_ready = 1'b0;
        pa = pc_cnt;
        send(32'h00500293);
        send(32'h00600313);
        check_eq("fl_skid_full", bus.in_ready, 0);
        flush = 1'b1;
        bus.in_insn = 32'h00700393;
        bus.in_pc   = pc_cnt;
        @(posedge clock); #1;
        flush = 1'b0;
        check_eq("fl_out_valid", bus.out_valid, 0);
        check_eq("fl_in_ready",  bus.in_ready,  1);
        check_eq("fl_pc_hold",   bus.out_pc,    pa);
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        check_eq("fl_dropped", bus.out_valid, 0);

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_insn   = rand_insn();
            bus.in_pc     = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 31) == 0);
            @(posedge clock); #1;
        end
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rnd_sb_empty",  sb.size(),     0);
        check_eq("rnd_out_valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
